// File: rtl/cache_sram_arbiter_pkg.sv
// Shared definitions for the cache-to-sram arbiter.
// Holds owner ids for the in-order owner FIFO, sram-like size encodings
// and the packed command bundle that is muxed toward the bridge.
package cache_sram_arbiter_pkg;

  // Owner id stored per accepted transaction
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // sram-like transfer size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Request fields forwarded from the grantee to the bridge
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/cache_sram_arbiter_owner_fifo.sv
// Owner FIFO: 1-bit wide, DEPTH entries, records who owns each accepted
// transaction so data_ok can be routed back in acceptance order.
// Ports: i_push/i_din enqueue, i_pop dequeue, o_full/o_empty status, o_head = oldest owner.
// A push while full is accepted only when a pop happens in the same cycle.
module cache_sram_arbiter_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop_ok) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cache_sram_arbiter.sv
// Arbiter sharing one sram-like bridge port between inst-cache and data-cache.
// Ports: inst_* / data_* requester sides, sram_* bridge side, proto_err sticky flag.
// Grant is combinational; data wins unless inst has waited STARVE_LIMIT data grants.
module cache_sram_arbiter
  import cache_sram_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  output logic        proto_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic            r_lock_vld;
  logic            r_lock_owner;
  logic [SC_W-1:0] r_starve_cnt;
  logic            r_proto_err;

  logic            w_grant;
  logic            w_grant_req;
  logic            w_starved;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_fifo_head;
  logic            w_pop;
  logic            w_blocked;
  logic            w_hs;
  sram_cmd_t       w_cmd;

  assign w_starved = (r_starve_cnt == SC_W'(STARVE_LIMIT));

  always_comb begin
    w_grant     = OWNER_DATA;
    w_grant_req = 1'b0;
    if (r_lock_vld) begin
      // An issued request must not be swapped out before the bridge takes it
      w_grant     = r_lock_owner;
      w_grant_req = (r_lock_owner == OWNER_INST) ? inst_req : data_req;
    end else if (w_starved && inst_req) begin
      w_grant     = OWNER_INST;
      w_grant_req = 1'b1;
    end else if (data_req) begin
      w_grant     = OWNER_DATA;
      w_grant_req = 1'b1;
    end else if (inst_req) begin
      w_grant     = OWNER_INST;
      w_grant_req = 1'b1;
    end
  end

  assign w_cmd = (w_grant == OWNER_INST) ?
                 sram_cmd_t'{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata} :
                 sram_cmd_t'{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  assign w_pop = sram_data_ok & ~w_fifo_empty;
  // A full FIFO still accepts a new address in the cycle its head is popped
  assign w_blocked = w_fifo_full & ~w_pop;

  assign sram_req   = w_grant_req & ~w_blocked & ~rst;
  assign sram_wr    = w_cmd.wr;
  assign sram_size  = w_cmd.size;
  assign sram_addr  = w_cmd.addr;
  assign sram_wdata = w_cmd.wdata;
  assign w_hs       = sram_req & sram_addr_ok;

  assign inst_addr_ok = w_hs & (w_grant == OWNER_INST);
  assign data_addr_ok = w_hs & (w_grant == OWNER_DATA);
  assign inst_data_ok = w_pop & (w_fifo_head == OWNER_INST) & ~rst;
  assign data_data_ok = w_pop & (w_fifo_head == OWNER_DATA) & ~rst;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;
  assign proto_err    = r_proto_err;

  cache_sram_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_hs),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= OWNER_INST;
      r_starve_cnt <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      // Blocked-by-full cycles have sram_req=0 and leave the lock alone
      if (w_hs) begin
        r_lock_vld <= 1'b0;
      end else if (sram_req) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= w_grant;
      end

      if (!inst_req || inst_addr_ok) begin
        r_starve_cnt <= '0;
      end else if (data_addr_ok && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end

      if (sram_data_ok && w_fifo_empty) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Directed table-driven bench for cache_sram_arbiter plus hand-written reset sequences.
// Inputs are driven on the falling edge and outputs sampled 2 time units later.
// Expected values are hand-computed per cycle for MAX_OUTSTANDING=2, STARVE_LIMIT=4.
module tb_cache_sram_arbiter;

  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h8000_0040;
  localparam logic [31:0] IWD = 32'h1111_1111;
  localparam logic [31:0] DWD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_addr_ok, sram_data_ok, proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_sram_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .proto_err(proto_err)
  );

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rd;
    logic        sreq;
    logic [31:0] saddr;
    logic        iaok, daok, idok, ddok, perr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ir, dr, aok, dok, input logic [31:0] rd,
                     input logic sreq, input logic [31:0] saddr,
                     input logic iaok, daok, idok, ddok, perr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
    v.sreq = sreq; v.saddr = saddr;
    v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok; v.perr = perr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [95:0] got, exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
  endtask

  initial begin
    logic [66:0] exp_fields;

    inst_wr = 1'b0; inst_size = 2'b10; inst_addr = IA; inst_wdata = IWD;
    data_wr = 1'b1; data_size = 2'b00; data_addr = DA; data_wdata = DWD;
    sram_rdata = 32'h0;

    // Reset: outputs quiet even with every input asserted
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    #2;
    check("rst_sram_req", -1, 96'(sram_req), 96'(0));
    check("rst_addr_ok", -1, 96'({inst_addr_ok, data_addr_ok}), 96'(0));
    check("rst_data_ok", -1, 96'({inst_data_ok, data_data_ok}), 96'(0));
    check("rst_proto_err", -1, 96'(proto_err), 96'(0));
    inst_req = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    //    ir dr aok dok rd            sreq saddr iaok daok idok ddok perr
    // single inst read, data_ok three cycles after acceptance
    add(1, 0, 1, 0, 32'h0,          1, IA, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, DA, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, DA, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h1234_5678,  0, DA, 0, 0, 1, 0, 0);
    // simultaneous requests: data first, responses in order
    add(1, 1, 1, 0, 32'h0,          1, DA, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,          1, IA, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'hAAAA_0001,  0, DA, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'hAAAA_0002,  0, DA, 0, 0, 1, 0, 0);
    // lock held for 2 cycles while inst_req rises
    add(0, 1, 0, 0, 32'h0,          1, DA, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 32'h0,          1, DA, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,          1, DA, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,          1, IA, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'hBBBB_0001,  0, DA, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'hBBBB_0002,  0, DA, 0, 0, 1, 0, 0);
    // fill FIFO, third request waits until the pop cycle
    add(0, 1, 1, 0, 32'h0,          1, DA, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0,          1, DA, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,          0, IA, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,          0, IA, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 32'hCCCC_0001,  1, IA, 1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'hCCCC_0002,  0, DA, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'hCCCC_0003,  0, DA, 0, 0, 1, 0, 0);
    // starvation: four data grants, then inst is forced
    add(1, 1, 1, 0, 32'h0,          1, DA, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 32'hDDDD_0001,  1, DA, 0, 1, 0, 1, 0);
    add(1, 1, 1, 1, 32'hDDDD_0002,  1, DA, 0, 1, 0, 1, 0);
    add(1, 1, 1, 1, 32'hDDDD_0003,  1, DA, 0, 1, 0, 1, 0);
    add(1, 1, 1, 1, 32'hDDDD_0004,  1, IA, 1, 0, 0, 1, 0);
    add(0, 1, 1, 1, 32'hDDDD_0005,  1, DA, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 32'hDDDD_0006,  0, DA, 0, 0, 0, 1, 0);
    // data_ok with empty FIFO
    add(0, 0, 0, 1, 32'hEEEE_0001,  0, DA, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, DA, 0, 0, 0, 0, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      inst_req = vq[i].ir; data_req = vq[i].dr;
      sram_addr_ok = vq[i].aok; sram_data_ok = vq[i].dok; sram_rdata = vq[i].rd;
      #2;
      exp_fields = (vq[i].saddr == IA) ? {1'b0, 2'b10, IWD} : {1'b1, 2'b00, DWD};
      check("sram_req", i, 96'(sram_req), 96'(vq[i].sreq));
      check("sram_addr", i, 96'(sram_addr), 96'(vq[i].saddr));
      check("sram_fields", i, 96'({sram_wr, sram_size, sram_wdata}), 96'(exp_fields));
      check("inst_addr_ok", i, 96'(inst_addr_ok), 96'(vq[i].iaok));
      check("data_addr_ok", i, 96'(data_addr_ok), 96'(vq[i].daok));
      check("inst_data_ok", i, 96'(inst_data_ok), 96'(vq[i].idok));
      check("data_data_ok", i, 96'(data_data_ok), 96'(vq[i].ddok));
      check("proto_err", i, 96'(proto_err), 96'(vq[i].perr));
      check("rdata", i, 96'({inst_rdata, data_rdata}), 96'({vq[i].rd, vq[i].rd}));
    end

    // Leave one transaction outstanding, then reset asynchronously mid-cycle
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b0;
    #2;
    check("pre_rst_push", 100, 96'(data_addr_ok), 96'(1));
    @(negedge clk);
    data_req = 1'b0; sram_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_perr", 101, 96'(proto_err), 96'(0));
    sram_data_ok = 1'b1;
    #1;
    check("rst_dok_gated", 102, 96'({inst_data_ok, data_data_ok}), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("late_dok_ignored", 103, 96'({inst_data_ok, data_data_ok}), 96'(0));
    @(negedge clk);
    sram_data_ok = 1'b0;
    #2;
    check("late_dok_perr", 104, 96'(proto_err), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
